column_mix: RTL and testbench

COLUMN_MIX -- requirements
Module: column_mix

---
 rtl/permute_pkg.sv | 24 ++
 rtl/column_parity.sv | 18 +
 rtl/column_mix.sv | 109 ++++++++++
 tb/tb_column_mix.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/permute_pkg.sv
// Shared definitions for the permutation stages: plane geometry, the
// load/emit state encoding, and bit <-> (x, y) index helpers.
package permute_pkg;

   localparam int PLANE_W = 25;
   localparam int ROW_W   = 5;

   typedef logic [0:0] state_t;
   localparam state_t LOAD = 1'b0;
   localparam state_t EMIT = 1'b1;

   function automatic int bit_x(input int i);
      return i % ROW_W;
   endfunction

   function automatic int bit_y(input int i);
      return i / ROW_W;
   endfunction

   function automatic int bit_idx(input int x, input int y);
      return ROW_W * y + x;
   endfunction

endpackage

// File: rtl/column_parity.sv
// Column parity of one 5x5 plane: parity[x] is the XOR of the five bits in column x.
module column_parity
   import permute_pkg::*;
(
   input  logic [PLANE_W-1:0] plane,
   output logic [ROW_W-1:0]   parity
);

   genvar gi;
   generate
      for (gi = 0; gi < ROW_W; gi++) begin : g_col
         assign parity[gi] = plane[bit_idx(gi, 0)] ^ plane[bit_idx(gi, 1)]
                           ^ plane[bit_idx(gi, 2)] ^ plane[bit_idx(gi, 3)]
                           ^ plane[bit_idx(gi, 4)];
      end
   endgenerate

endmodule

// File: rtl/column_mix.sv
// Column-mix stage: buffers a frame of DEPTH slices with their column parities,
// then emits each slice XORed with the mix of neighbouring column parities.
module column_mix
   import permute_pkg::*;
#(
   parameter int DEPTH = 4
)
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [PLANE_W-1:0] in_slice,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [PLANE_W-1:0] out_slice,
   output logic               out_last
);

   localparam int CW = $clog2(DEPTH);
   localparam logic [CW-1:0] LAST_IDX = CW'(DEPTH - 1);

   state_t             state_reg, state_next;
   logic [CW-1:0]      load_cnt_reg, load_cnt_next;
   logic [CW-1:0]      emit_cnt_reg, emit_cnt_next;
   logic [CW-1:0]      rd_addr;
   logic [CW-1:0]      prev_idx;
   logic               in_fire, out_fire;

   logic [PLANE_W-1:0] slice_mem [DEPTH];
   logic [ROW_W-1:0]   parity_mem [DEPTH];
   logic [PLANE_W-1:0] slice_rd_reg;

   logic [ROW_W-1:0]   in_parity;
   logic [ROW_W-1:0]   c_cur, c_prev, mix_term;
   logic [PLANE_W-1:0] mixed;

   function automatic logic [CW-1:0] wrap_inc(input logic [CW-1:0] v);
      return (v == LAST_IDX) ? '0 : v + CW'(1);
   endfunction

   column_parity u_parity (
      .plane  (in_slice),
      .parity (in_parity)
   );

   assign in_ready  = (state_reg == LOAD);
   assign out_valid = (state_reg == EMIT);
   assign in_fire   = in_valid & in_ready;
   assign out_fire  = out_valid & out_ready;

   always_comb begin
      state_next    = state_reg;
      load_cnt_next = load_cnt_reg;
      emit_cnt_next = emit_cnt_reg;
      if (in_fire) begin
         load_cnt_next = wrap_inc(load_cnt_reg);
         if (load_cnt_reg == LAST_IDX) state_next = EMIT;
      end
      if (out_fire) begin
         emit_cnt_next = wrap_inc(emit_cnt_reg);
         if (emit_cnt_reg == LAST_IDX) state_next = LOAD;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg    <= LOAD;
         load_cnt_reg <= '0;
         emit_cnt_reg <= '0;
      end else begin
         state_reg    <= state_next;
         load_cnt_reg <= load_cnt_next;
         emit_cnt_reg <= emit_cnt_next;
      end
   end

   // Read address runs one slice ahead on a handshake so the registered read
   // lines up with emit_cnt_reg; in LOAD it parks on slice 0 for the first output.
   assign rd_addr = out_fire ? wrap_inc(emit_cnt_reg) : emit_cnt_reg;

   always_ff @(posedge clk) begin
      if (in_fire) slice_mem[load_cnt_reg] <= in_slice;
      slice_rd_reg <= slice_mem[rd_addr];
   end

   always_ff @(posedge clk) begin
      if (in_fire) parity_mem[load_cnt_reg] <= in_parity;
   end

   assign prev_idx = (emit_cnt_reg == '0) ? LAST_IDX : emit_cnt_reg - CW'(1);
   assign c_cur    = parity_mem[emit_cnt_reg];
   assign c_prev   = parity_mem[prev_idx];

   genvar gi;
   generate
      for (gi = 0; gi < ROW_W; gi++) begin : g_mix
         assign mix_term[gi] = c_cur[(gi + 4) % ROW_W] ^ c_prev[(gi + 1) % ROW_W];
      end
      for (gi = 0; gi < PLANE_W; gi++) begin : g_out
         assign mixed[gi] = slice_rd_reg[gi] ^ mix_term[bit_x(gi)];
      end
   endgenerate

   // Gating keeps stale buffer contents off the output while loading.
   assign out_slice = out_valid ? mixed : '0;
   assign out_last  = out_valid && (emit_cnt_reg == LAST_IDX);

endmodule

// File: tb/tb_column_mix.sv
// Bench for column_mix at DEPTH=4: directed frames, stall, mid-frame reset,
// back-to-back and random-handshake frames checked against a parity model.
module tb_column_mix;

   localparam int DEPTH = 4;
   localparam int NF    = 3;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic [24:0] in_slice = '0;
   logic        in_ready, out_valid, out_last;
   logic [24:0] out_slice;

   int total = 0;
   int bad   = 0;

   logic [24:0] frame_in [DEPTH];
   logic [24:0] exp_out  [DEPTH];
   logic [24:0] got_out  [DEPTH];
   logic        got_last [DEPTH];
   int          first_cyc;
   bit          timed_out;

   logic [24:0] lit_single [DEPTH] = '{25'h0210843, 25'h1084210, 25'h0000000, 25'h0000000};
   logic [24:0] lit_wrap   [DEPTH] = '{25'h1084210, 25'h0000000, 25'h0000000, 25'h0210843};

   always #5 clk = ~clk;

   column_mix #(.DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_slice  (in_slice),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_slice (out_slice),
      .out_last  (out_last)
   );

   // Reference: column parities per slice, then each bit flipped by the
   // left-neighbour column of this slice and right-neighbour column of slice z-1.
   function automatic void model();
      logic c [5][DEPTH];
      for (int z = 0; z < DEPTH; z++)
         for (int x = 0; x < 5; x++) begin
            c[x][z] = 1'b0;
            for (int y = 0; y < 5; y++) c[x][z] = c[x][z] ^ frame_in[z][5*y + x];
         end
      for (int z = 0; z < DEPTH; z++) begin
         int prev;
         prev = (z + DEPTH - 1) % DEPTH;
         for (int i = 0; i < 25; i++) begin
            int x;
            x = i % 5;
            exp_out[z][i] = frame_in[z][i] ^ c[(x + 4) % 5][z] ^ c[(x + 1) % 5][prev];
         end
      end
   endfunction

   task automatic load_frame();
      for (int z = 0; z < DEPTH; z++) begin
         @(negedge clk);
         in_valid  = 1'b1;
         in_slice  = frame_in[z];
         out_ready = 1'b0;
         @(posedge clk);
      end
   endtask

   task automatic load_partial(input int n);
      for (int z = 0; z < n; z++) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_slice = $urandom;
         @(posedge clk);
      end
   endtask

   task automatic collect_frame(input int start);
      int n;
      int cyc;
      n = start;
      cyc = 0;
      first_cyc = -1;
      while (n < DEPTH && cyc < 50) begin
         @(negedge clk);
         in_valid  = 1'b0;
         in_slice  = $urandom;
         out_ready = 1'b1;
         #1;
         if (out_valid) begin
            if (first_cyc < 0) first_cyc = cyc;
            got_out[n]  = out_slice;
            got_last[n] = out_last;
            $display("xfer z=%0d out=%h last=%0b", n, out_slice, out_last);
            n++;
         end
         cyc++;
      end
      timed_out = (n < DEPTH);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) begin
         @(negedge clk);
         in_valid = 1'($urandom);
         in_slice = $urandom;
      end
      @(negedge clk);
      rst_n = 1'b1;
      in_valid = 1'b0;
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
      total++; if (out_last !== 1'b0) begin bad++; $display("FAIL reset_out_last got=%b want=0", out_last); end
      total++; if (out_slice !== 25'h0) begin bad++; $display("FAIL reset_out_slice got=%h want=0000000", out_slice); end
   endtask

   task automatic test_zero_frame();
      for (int z = 0; z < DEPTH; z++) frame_in[z] = '0;
      load_frame();
      collect_frame(0);
      total++; if (timed_out) begin bad++; $display("FAIL zero_timeout got=timeout want=%0d outputs", DEPTH); end
      for (int z = 0; z < DEPTH; z++) begin
         total++; if (got_out[z] !== 25'h0) begin bad++; $display("FAIL zero_out[%0d] got=%h want=0000000", z, got_out[z]); end
         total++; if (got_last[z] !== (z == DEPTH - 1)) begin bad++; $display("FAIL zero_last[%0d] got=%b want=%b", z, got_last[z], z == DEPTH - 1); end
      end
   endtask

   task automatic test_single_bit();
      for (int z = 0; z < DEPTH; z++) frame_in[z] = '0;
      frame_in[0] = 25'h0000001;
      model();
      load_frame();
      collect_frame(0);
      total++; if (first_cyc !== 0) begin bad++; $display("FAIL single_latency got=%0d want=0", first_cyc); end
      for (int z = 0; z < DEPTH; z++) begin
         total++; if (got_out[z] !== lit_single[z]) begin bad++; $display("FAIL single_out[%0d] got=%h want=%h", z, got_out[z], lit_single[z]); end
         total++; if (got_out[z] !== exp_out[z]) begin bad++; $display("FAIL single_model[%0d] got=%h want=%h", z, got_out[z], exp_out[z]); end
      end
   endtask

   task automatic test_wrap();
      for (int z = 0; z < DEPTH; z++) frame_in[z] = '0;
      frame_in[DEPTH - 1] = 25'h0000001;
      load_frame();
      collect_frame(0);
      for (int z = 0; z < DEPTH; z++) begin
         total++; if (got_out[z] !== lit_wrap[z]) begin bad++; $display("FAIL wrap_out[%0d] got=%h want=%h", z, got_out[z], lit_wrap[z]); end
      end
   endtask

   task automatic test_stall();
      for (int z = 0; z < DEPTH; z++) frame_in[z] = $urandom;
      model();
      load_frame();
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      #1;
      total++; if (out_slice !== exp_out[0]) begin bad++; $display("FAIL stall_out0 got=%h want=%h", out_slice, exp_out[0]); end
      @(negedge clk);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_slice  = $urandom;
      #1;
      total++; if (out_slice !== exp_out[1]) begin bad++; $display("FAIL stall_out1 got=%h want=%h", out_slice, exp_out[1]); end
      repeat (2) begin
         @(negedge clk);
         in_slice = $urandom;
         #1;
         total++; if (out_slice !== exp_out[1]) begin bad++; $display("FAIL stall_hold_slice got=%h want=%h", out_slice, exp_out[1]); end
         total++; if (out_last !== 1'b0) begin bad++; $display("FAIL stall_hold_last got=%b want=0", out_last); end
         total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready got=%b want=0", in_ready); end
         total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL stall_out_valid got=%b want=1", out_valid); end
      end
      collect_frame(1);
      total++; if (timed_out) begin bad++; $display("FAIL stall_timeout got=timeout want=%0d outputs", DEPTH); end
      for (int z = 1; z < DEPTH; z++) begin
         total++; if (got_out[z] !== exp_out[z]) begin bad++; $display("FAIL stall_out[%0d] got=%h want=%h", z, got_out[z], exp_out[z]); end
         total++; if (got_last[z] !== (z == DEPTH - 1)) begin bad++; $display("FAIL stall_last[%0d] got=%b want=%b", z, got_last[z], z == DEPTH - 1); end
      end
   endtask

   task automatic test_reset_mid();
      load_partial(2);
      @(negedge clk);
      in_valid = 1'b0;
      rst_n    = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rstmid_in_ready got=%b want=1", in_ready); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_out_valid got=%b want=0", out_valid); end
      for (int z = 0; z < DEPTH; z++) frame_in[z] = '0;
      frame_in[0] = 25'h0000001;
      load_frame();
      collect_frame(0);
      total++; if (first_cyc !== 0) begin bad++; $display("FAIL rstmid_latency got=%0d want=0", first_cyc); end
      for (int z = 0; z < DEPTH; z++) begin
         total++; if (got_out[z] !== lit_single[z]) begin bad++; $display("FAIL rstmid_out[%0d] got=%h want=%h", z, got_out[z], lit_single[z]); end
      end
   endtask

   task automatic test_back_to_back();
      logic [24:0] all_in  [2*DEPTH];
      logic [24:0] all_exp [2*DEPTH];
      logic [24:0] all_got [2*DEPTH];
      logic        all_lst [2*DEPTH];
      int si, no, cyc, last_cyc;
      for (int f = 0; f < 2; f++) begin
         for (int z = 0; z < DEPTH; z++) begin
            frame_in[z] = $urandom;
            all_in[f*DEPTH + z] = frame_in[z];
         end
         model();
         for (int z = 0; z < DEPTH; z++) all_exp[f*DEPTH + z] = exp_out[z];
      end
      si = 0; no = 0; cyc = 0; last_cyc = -1;
      while (no < 2*DEPTH && cyc < 60) begin
         @(negedge clk);
         in_valid  = 1'b1;
         in_slice  = (si < 2*DEPTH) ? all_in[si] : 25'($urandom);
         out_ready = 1'b1;
         #1;
         if (in_ready) si++;
         if (out_valid) begin
            all_got[no] = out_slice;
            all_lst[no] = out_last;
            $display("xfer b2b n=%0d out=%h last=%0b", no, out_slice, out_last);
            no++;
            last_cyc = cyc;
         end
         cyc++;
      end
      total++; if (no !== 2*DEPTH) begin bad++; $display("FAIL b2b_count got=%0d want=%0d", no, 2*DEPTH); end
      total++; if (last_cyc !== 4*DEPTH - 1) begin bad++; $display("FAIL b2b_cycles got=%0d want=%0d", last_cyc + 1, 4*DEPTH); end
      for (int k = 0; k < no; k++) begin
         total++; if (all_got[k] !== all_exp[k]) begin bad++; $display("FAIL b2b_out[%0d] got=%h want=%h", k, all_got[k], all_exp[k]); end
         total++; if (all_lst[k] !== ((k % DEPTH) == DEPTH - 1)) begin bad++; $display("FAIL b2b_last[%0d] got=%b want=%b", k, all_lst[k], (k % DEPTH) == DEPTH - 1); end
      end
   endtask

   task automatic test_random();
      logic [24:0] all_in  [NF*DEPTH];
      logic [24:0] all_exp [NF*DEPTH];
      logic [24:0] all_got [NF*DEPTH];
      logic        all_lst [NF*DEPTH];
      int si, no, cyc;
      for (int f = 0; f < NF; f++) begin
         for (int z = 0; z < DEPTH; z++) begin
            frame_in[z] = $urandom;
            all_in[f*DEPTH + z] = frame_in[z];
         end
         model();
         for (int z = 0; z < DEPTH; z++) all_exp[f*DEPTH + z] = exp_out[z];
      end
      si = 0; no = 0; cyc = 0;
      while (no < NF*DEPTH && cyc < 400) begin
         @(negedge clk);
         in_valid  = (si < NF*DEPTH) ? 1'($urandom) : 1'b0;
         in_slice  = (si < NF*DEPTH) ? all_in[si] : 25'($urandom);
         out_ready = 1'($urandom);
         #1;
         if (in_valid && in_ready) si++;
         if (out_valid && out_ready) begin
            all_got[no] = out_slice;
            all_lst[no] = out_last;
            $display("xfer rnd n=%0d out=%h last=%0b", no, out_slice, out_last);
            no++;
         end
         cyc++;
      end
      total++; if (no !== NF*DEPTH) begin bad++; $display("FAIL rnd_count got=%0d want=%0d", no, NF*DEPTH); end
      for (int k = 0; k < no; k++) begin
         total++; if (all_got[k] !== all_exp[k]) begin bad++; $display("FAIL rnd_out[%0d] got=%h want=%h", k, all_got[k], all_exp[k]); end
         total++; if (all_lst[k] !== ((k % DEPTH) == DEPTH - 1)) begin bad++; $display("FAIL rnd_last[%0d] got=%b want=%b", k, all_lst[k], (k % DEPTH) == DEPTH - 1); end
      end
   endtask

   initial begin
      test_reset();
      test_zero_frame();
      test_single_bit();
      test_wrap();
      test_stall();
      test_reset_mid();
      test_back_to_back();
      test_random();
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
